// File: rtl/quiz_arbiter.sv
// Three-contestant quiz arbiter: synchronized buttons, countdown answer window, fouls, buzzer.
// Optional macro QUIZ_SCORE_EN adds i_judge and three saturating 4-bit scores on o_score.
module quiz_arbiter #(
   parameter int unsigned TICK_DIV = 50_000_000,
   parameter int unsigned WIN_S    = 9,
   parameter int unsigned BUZ_CYC  = 25_000_000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_ask,
   input  logic [2:0]  i_ans,
   input  logic        i_clr,
   output logic [1:0]  o_winner,
   output logic [3:0]  o_cnt,
   output logic [2:0]  o_foul,
   output logic [2:0]  o_state,
   output logic        o_buz
`ifdef QUIZ_SCORE_EN
   ,
   input  logic        i_judge,
   output logic [11:0] o_score
`endif
);

   localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned BuzW = (BUZ_CYC > 0) ? $clog2(BUZ_CYC + 1) : 1;
   localparam logic [PreW-1:0] PreMax = PreW'(TICK_DIV - 1);
   localparam logic [PreW-1:0] PreOne = PreW'(1);
   localparam logic [BuzW-1:0] BuzLoad = BuzW'(BUZ_CYC);
   localparam logic [BuzW-1:0] BuzOne = BuzW'(1);
   localparam logic [3:0] WinLoad = 4'(WIN_S);

   typedef enum logic [2:0] {
      StTimeout = 3'b000,
      StIdle    = 3'b001,
      StArmed   = 3'b010,
      StLocked  = 3'b100
   } state_e;

   state_e          state_q, state_d;
   logic [1:0]      winner_q, winner_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [2:0]      foul_q, foul_d;
   logic [2:0]      excl_q, excl_d;
   logic [PreW-1:0] pre_q, pre_d;
   logic            buz_trig_q, buz_trig_d;
   logic [BuzW-1:0] buz_cnt_q;

   logic [1:0] ask_sync_q, clr_sync_q;
   logic       ask_prev_q, clr_prev_q;
   logic [2:0] ans_sync1_q, ans_sync2_q;
   logic       ask_edge, clr_edge, tick;
   logic [2:0] press, valid;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         // Level buttons reset as if already high, so one held through reset never edges.
         ask_sync_q  <= 2'b11;
         ask_prev_q  <= 1'b1;
         clr_sync_q  <= 2'b11;
         clr_prev_q  <= 1'b1;
         ans_sync1_q <= 3'b111;
         ans_sync2_q <= 3'b111;
      end else begin
         ask_sync_q  <= {ask_sync_q[0], i_ask};
         ask_prev_q  <= ask_sync_q[1];
         clr_sync_q  <= {clr_sync_q[0], i_clr};
         clr_prev_q  <= clr_sync_q[1];
         ans_sync1_q <= i_ans;
         ans_sync2_q <= ans_sync1_q;
      end
   end

   assign ask_edge = ask_sync_q[1] & ~ask_prev_q;
   assign clr_edge = clr_sync_q[1] & ~clr_prev_q;
   assign press    = ~ans_sync2_q;
   assign valid    = press & ~excl_q;
   assign tick     = (pre_q == PreMax);

   always_comb begin
      state_d    = state_q;
      winner_d   = winner_q;
      cnt_d      = cnt_q;
      foul_d     = foul_q;
      excl_d     = excl_q;
      pre_d      = '0;
      buz_trig_d = 1'b0;
      if (clr_edge) begin
         state_d  = StIdle;
         winner_d = 2'd3;
         cnt_d    = 4'd0;
         foul_d   = 3'b000;
         excl_d   = 3'b000;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (ask_edge) begin
                  // Fouls become this round's exclusion mask, then the visible flags clear.
                  state_d = StArmed;
                  cnt_d   = WinLoad;
                  excl_d  = foul_q | press;
                  foul_d  = 3'b000;
               end else begin
                  foul_d     = foul_q | press;
                  buz_trig_d = |(press & ~foul_q);
               end
            end
            StArmed: begin
               pre_d = tick ? '0 : pre_q + PreOne;
               if (valid != 3'b000) begin
                  state_d    = StLocked;
                  buz_trig_d = 1'b1;
                  if (valid[0])      winner_d = 2'd0;
                  else if (valid[1]) winner_d = 2'd1;
                  else               winner_d = 2'd2;
               end else if (tick) begin
                  cnt_d = cnt_q - 4'd1;
                  if (cnt_q == 4'd1) begin
                     state_d    = StTimeout;
                     buz_trig_d = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= StIdle;
         winner_q <= 2'd3;
         cnt_q    <= 4'd0;
         foul_q   <= 3'b000;
         excl_q   <= 3'b000;
         pre_q    <= '0;
      end else begin
         state_q  <= state_d;
         winner_q <= winner_d;
         cnt_q    <= cnt_d;
         foul_q   <= foul_d;
         excl_q   <= excl_d;
         pre_q    <= pre_d;
      end
   end

   // Trigger is registered so the pulse starts the cycle after the triggering state change.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         buz_trig_q <= 1'b0;
         buz_cnt_q  <= '0;
      end else if (clr_edge) begin
         buz_trig_q <= 1'b0;
         buz_cnt_q  <= '0;
      end else begin
         buz_trig_q <= buz_trig_d;
         if (buz_trig_q)             buz_cnt_q <= BuzLoad;
         else if (buz_cnt_q != '0)   buz_cnt_q <= buz_cnt_q - BuzOne;
      end
   end

   assign o_winner = winner_q;
   assign o_cnt    = cnt_q;
   assign o_foul   = foul_q;
   assign o_state  = state_q;
   assign o_buz    = (buz_cnt_q != '0);

`ifdef QUIZ_SCORE_EN
   logic [1:0]      judge_sync_q;
   logic            judge_prev_q, judged_q, judge_edge;
   logic [2:0][3:0] score_q;

   assign judge_edge = judge_sync_q[1] & ~judge_prev_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         judge_sync_q <= 2'b11;
         judge_prev_q <= 1'b1;
         judged_q     <= 1'b0;
         score_q      <= '0;
      end else begin
         judge_sync_q <= {judge_sync_q[0], i_judge};
         judge_prev_q <= judge_sync_q[1];
         if (state_q == StIdle) begin
            judged_q <= 1'b0;
         end else if (state_q == StLocked && judge_edge && !judged_q) begin
            judged_q <= 1'b1;
            if (score_q[winner_q] != 4'hF) score_q[winner_q] <= score_q[winner_q] + 4'd1;
         end
      end
   end

   assign o_score = score_q;
`endif

endmodule

// File: tb/tb_quiz_arbiter.sv
// Self-checking bench for quiz_arbiter (TICK_DIV=10, WIN_S=3, BUZ_CYC=4): vector table,
// scoreboard queue for round outcomes, and hand sequences for timing corner cases.
module tb_quiz_arbiter;

   logic       i_clk   = 1'b0;
   logic       i_rst_n = 1'b1;
   logic       i_ask   = 1'b0;
   logic       i_clr   = 1'b0;
   logic [2:0] i_ans   = 3'b111;
   logic [1:0] o_winner;
   logic [3:0] o_cnt;
   logic [2:0] o_foul;
   logic [2:0] o_state;
   logic       o_buz;
`ifdef QUIZ_SCORE_EN
   logic        i_judge = 1'b0;
   logic [11:0] o_score;
`endif

   quiz_arbiter #(
      .TICK_DIV(10),
      .WIN_S   (3),
      .BUZ_CYC (4)
   ) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_ask   (i_ask),
      .i_ans   (i_ans),
      .i_clr   (i_clr),
      .o_winner(o_winner),
      .o_cnt   (o_cnt),
      .o_foul  (o_foul),
      .o_state (o_state),
`ifdef QUIZ_SCORE_EN
      .o_buz   (o_buz),
      .i_judge (i_judge),
      .o_score (o_score)
`else
      .o_buz   (o_buz)
`endif
   );

   always #5 i_clk = ~i_clk;

   localparam logic [2:0] SIdle = 3'b001, SArmed = 3'b010, SLocked = 3'b100, STimeout = 3'b000;

   typedef struct {
      logic [2:0] idle_ans;
      logic [2:0] arm_ans;
      logic [2:0] exp_foul;
      logic [1:0] exp_win;
      logic [2:0] exp_state;
      logic [3:0] exp_cnt;
   } vec_t;

   typedef struct {
      logic [1:0] win;
      logic [2:0] state;
      logic [3:0] cnt;
   } exp_t;

   int   total = 0;
   int   bad   = 0;
   exp_t sb[$];
   vec_t vecs[8];

   task automatic step(input int n);
      repeat (n) begin
         @(posedge i_clk);
         #1;
      end
   endtask

   task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_clr();
      i_clr = 1'b1;
      step(4);
      i_clr = 1'b0;
      step(1);
   endtask

   task automatic arm();
      i_ask = 1'b1;
      step(3);
      i_ask = 1'b0;
   endtask

   task automatic wait_leave(input int budget, output int n);
      n = 0;
      while (o_state == SArmed && n < budget) begin
         step(1);
         n++;
      end
      if (n >= budget) begin
         total++;
         bad++;
         $display("FAIL armed_wait: still armed after %0d cycles, required exit", n);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int         n;
      int         hi;
      exp_t       e;
      logic [3:0] seq[$];
      logic [3:0] last;

      vecs[0] = '{3'b111, 3'b110, 3'b000, 2'd0, SLocked,  4'd3};
      vecs[1] = '{3'b011, 3'b010, 3'b100, 2'd0, SLocked,  4'd3};
      vecs[2] = '{3'b111, 3'b001, 3'b000, 2'd1, SLocked,  4'd3};
      vecs[3] = '{3'b111, 3'b000, 3'b000, 2'd0, SLocked,  4'd3};
      vecs[4] = '{3'b110, 3'b100, 3'b001, 2'd1, SLocked,  4'd3};
      vecs[5] = '{3'b111, 3'b111, 3'b000, 2'd3, STimeout, 4'd0};
      vecs[6] = '{3'b100, 3'b110, 3'b011, 2'd3, STimeout, 4'd0};
      vecs[7] = '{3'b111, 3'b011, 3'b000, 2'd2, SLocked,  4'd3};

      // Reset state
      #2 i_rst_n = 1'b0;
      #1;
      check("rst_state", o_state, SIdle);
      check("rst_winner", o_winner, 2'd3);
      check("rst_cnt", o_cnt, 4'd0);
      check("rst_foul", o_foul, 3'b000);
      check("rst_buz", o_buz, 1'b0);
      step(3);
      i_rst_n = 1'b1;
      step(3);
      check("post_rst_state", o_state, SIdle);

      // Table-driven rounds, outcomes through the scoreboard
      for (int i = 0; i < 8; i++) begin
         do_clr();
         check("clr_state", o_state, SIdle);
         check("clr_winner", o_winner, 2'd3);
         if (vecs[i].idle_ans != 3'b111) begin
            i_ans = vecs[i].idle_ans;
            step(4);
            i_ans = 3'b111;
            step(3);
         end
         check("idle_foul", o_foul, vecs[i].exp_foul);
         arm();
         check("armed_state", o_state, SArmed);
         check("armed_cnt", o_cnt, 4'd3);
         check("armed_foul_clr", o_foul, 3'b000);
         step(5);
         i_ans = vecs[i].arm_ans;
         sb.push_back('{win: vecs[i].exp_win, state: vecs[i].exp_state, cnt: vecs[i].exp_cnt});
         wait_leave(40, n);
         i_ans = 3'b111;
         e = sb.pop_front();
         check("round_winner", o_winner, e.win);
         check("round_state", o_state, e.state);
         check("round_cnt", o_cnt, e.cnt);
      end

      // Buzzer pulse after a lock
      do_clr();
      arm();
      step(5);
      i_ans = 3'b110;
      wait_leave(40, n);
      check("lock_state", o_state, SLocked);
      check("buz_at_entry", o_buz, 1'b0);
      step(1);
      check("buz_first", o_buz, 1'b1);
      hi = 1;
      for (int k = 0; k < 9; k++) begin
         step(1);
         if (o_buz) hi++;
      end
      check("buz_len", 12'(hi), 12'd4);
      i_ans = 3'b111;

      // Countdown to timeout
      do_clr();
      arm();
      seq.delete();
      last = o_cnt;
      seq.push_back(o_cnt);
      n = 0;
      while (o_state == SArmed && n < 60) begin
         step(1);
         n++;
         if (o_cnt != last) begin
            last = o_cnt;
            seq.push_back(o_cnt);
         end
      end
      check("timeout_cycles", 12'(n), 12'd30);
      check("cnt_values", 12'(seq.size()), 12'd4);
      for (int k = 0; k < 4; k++)
         check("cnt_seq", (k < seq.size()) ? seq[k] : 4'hF, 4'(3 - k));
      check("timeout_state", o_state, STimeout);
      check("timeout_winner", o_winner, 2'd3);
      hi = 0;
      for (int k = 0; k < 8; k++) begin
         step(1);
         if (o_buz) hi++;
      end
      check("timeout_buz_len", 12'(hi), 12'd4);

      // Press on the final-tick cycle wins; one cycle later is too late
      do_clr();
      arm();
      step(27);
      i_ans = 3'b101;
      step(3);
      check("final_tick_state", o_state, SLocked);
      check("final_tick_winner", o_winner, 2'd1);
      check("final_tick_cnt", o_cnt, 4'd1);
      i_ans = 3'b111;
      do_clr();
      arm();
      step(28);
      i_ans = 3'b101;
      step(3);
      check("late_state", o_state, STimeout);
      check("late_winner", o_winner, 2'd3);
      check("late_cnt", o_cnt, 4'd0);
      i_ans = 3'b111;

      // Reset mid-round with i_ask held
      do_clr();
      i_ask = 1'b1;
      step(3);
      check("hold_armed", o_state, SArmed);
      #2 i_rst_n = 1'b0;
      #1;
      check("midrst_state", o_state, SIdle);
      check("midrst_cnt", o_cnt, 4'd0);
      step(2);
      i_rst_n = 1'b1;
      step(10);
      check("held_ask_no_arm", o_state, SIdle);
      i_ask = 1'b0;
      step(4);
      i_ask = 1'b1;
      step(3);
      check("rearm_state", o_state, SArmed);
      i_ask = 1'b0;

      // Second foul during a pulse restarts the buzzer
      do_clr();
      i_ans = 3'b110;
      step(2);
      i_ans = 3'b100;
      hi = 0;
      for (int k = 0; k < 14; k++) begin
         step(1);
         if (o_buz) hi++;
      end
      check("buz_restart_len", 12'(hi), 12'd6);
      check("two_fouls", o_foul, 3'b011);
      i_ans = 3'b111;

`ifdef QUIZ_SCORE_EN
      do_clr();
      for (int r = 0; r < 16; r++) begin
         arm();
         step(2);
         i_ans = 3'b011;
         wait_leave(40, n);
         i_ans = 3'b111;
         i_judge = 1'b1;
         step(3);
         i_judge = 1'b0;
         step(3);
         i_judge = 1'b1;
         step(3);
         i_judge = 1'b0;
         step(2);
         if (r == 0) check("score_once", o_score[11:8], 4'd1);
         do_clr();
      end
      check("score_sat", o_score[11:8], 4'd15);
      check("score_others", o_score[7:0], 8'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
